seq_det_ctrl: RTL and testbench

- Front-end controller for the team's serial Mealy pattern detector.
- Accepts parallel words over a valid/ready handshake and serializes them MSB-first.
- Runs a programmable PAT_LEN-bit pattern match on the continuous bit stream, with overlap and non-overlap modes.
- Counts matches and reports per-word completion, so upstream logic can drive detection without bit-level sequencing.

---
 rtl/seq_det_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Purpose: accepts parallel words, serializes them MSB-first and runs a programmable
//          PAT_LEN-bit Mealy pattern match with overlap/non-overlap modes and a saturating match counter.
// Latency: first ser_valid 1 cycle after the accepting edge; y and match_count update on the edge consuming the bit;
//          one word every WIDTH+2 cycles.
// Backpressure: in_ready is high only in IDLE; no word is taken while shifting or completing a word.
module seq_det_ctrl #(
  parameter int unsigned        WIDTH   = 8,
  parameter int unsigned        PAT_LEN = 4,
  parameter int unsigned        CNT_W   = 8,
  parameter logic [PAT_LEN-1:0] RST_PAT = 4'b0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               ser_bit,
  output logic               ser_valid,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               sat,
  output logic               word_done,
  output logic               busy
);

  // Bit counter spans 0..WIDTH-1; history counter spans 0..PAT_LEN.
  localparam int unsigned BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned HC_W = $clog2(PAT_LEN + 1);

  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [HC_W-1:0]  HC_ARMED = HC_W'(PAT_LEN - 1);
  localparam logic [HC_W-1:0]  HC_FULL  = HC_W'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Serializer datapath
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]  bitcnt_q, bitcnt_d;

  // Match configuration and stream history
  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic               overlap_q, overlap_d;
  logic [PAT_LEN-1:0] history_q, history_d;
  logic [HC_W-1:0]    hist_cnt_q, hist_cnt_d;

  // Match reporting
  logic             y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Shared decode of the current cycle
  logic               accept;
  logic               cfg_take;
  logic               shift_en;
  logic               cur_bit;
  logic [PAT_LEN-1:0] cand;
  logic               match;

  assign accept   = (state_q == S_IDLE) && in_valid;
  // A config write loses to a word accepted in the same cycle and is dropped, not queued.
  assign cfg_take = (state_q == S_IDLE) && !in_valid && cfg_we;
  assign shift_en = (state_q == S_SHIFT);
  assign cur_bit  = shreg_q[WIDTH-1];
  // Candidate window: the PAT_LEN-1 most recent bits plus the bit on the wire now.
  assign cand     = {history_q[PAT_LEN-2:0], cur_bit};
  assign match    = shift_en && (hist_cnt_q >= HC_ARMED) && (cand == pattern_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> SHIFT on accept, SHIFT -> DONE after the last bit, DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bitcnt_q == LAST_BIT) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    word_done = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_bit   = cur_bit;
        busy      = 1'b1;
      end
      S_DONE: begin
        word_done = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign y           = y_q;
  assign match_count = cnt_q;
  assign sat         = sat_q;

  // Serializer: load on accept, shift left one bit per SHIFT cycle
  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (accept) begin
      shreg_d  = in_data;
      bitcnt_d = '0;
    end else if (shift_en) begin
      shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
      bitcnt_d = bitcnt_q + BC_W'(1);
    end
  end

  // Serializer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Matcher: config writes restart the history; shifting slides the window across word boundaries
  always_comb begin
    pattern_d  = pattern_q;
    overlap_d  = overlap_q;
    history_d  = history_q;
    hist_cnt_d = hist_cnt_q;
    y_d        = 1'b0;
    if (cfg_take) begin
      pattern_d  = cfg_pattern;
      overlap_d  = cfg_overlap;
      history_d  = '0;
      hist_cnt_d = '0;
    end else if (shift_en) begin
      history_d = cand;
      y_d       = match;
      if (match && !overlap_q) begin
        // Non-overlap: the matched bits may not be reused, so re-arm after PAT_LEN-1 fresh bits.
        hist_cnt_d = '0;
      end else if (hist_cnt_q != HC_FULL) begin
        hist_cnt_d = hist_cnt_q + HC_W'(1);
      end
    end
  end

  // Matcher registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q  <= RST_PAT;
      overlap_q  <= 1'b1;
      history_q  <= '0;
      hist_cnt_q <= '0;
      y_q        <= 1'b0;
    end else begin
      pattern_q  <= pattern_d;
      overlap_q  <= overlap_d;
      history_q  <= history_d;
      hist_cnt_q <= hist_cnt_d;
      y_q        <= y_d;
    end
  end

  // Saturating match counter; a clear wins over a coincident match
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (cnt_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_MAX) begin
        sat_d = 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Purpose: self-checking bench for seq_det_ctrl, two instances (8-bit and 2-bit counters) on shared inputs.
// Latency: checks every cycle of every word at 1 time unit after the rising edge.
// Backpressure: words are offered only when in_ready is expected high.
module tb_seq_det_ctrl;

  localparam int PAT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_pattern = 4'd0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;

  logic       in_ready, ser_bit, ser_valid, y, sat, word_done, busy;
  logic [7:0] match_count;
  logic       in_ready2, ser_bit2, ser_valid2, y2, sat2, word_done2, busy2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  // Reference model: recent bits since the last restart point, config and counters.
  bit   hist[$];
  logic [3:0] m_pat;
  bit   m_ovl;
  bit   exp_y;
  int   m_cnt8, m_cnt2;
  bit   m_sat8, m_sat2;

  seq_det_ctrl #(.WIDTH(8), .PAT_LEN(4), .CNT_W(8), .RST_PAT(4'b0001)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ser_bit(ser_bit), .ser_valid(ser_valid), .y(y),
    .match_count(match_count), .sat(sat), .word_done(word_done), .busy(busy)
  );

  seq_det_ctrl #(.WIDTH(8), .PAT_LEN(4), .CNT_W(2), .RST_PAT(4'b0001)) dut2 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .ser_bit(ser_bit2), .ser_valid(ser_valid2), .y(y2),
    .match_count(cnt2), .sat(sat2), .word_done(word_done2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    hist.delete();
    m_pat  = 4'b0001;
    m_ovl  = 1'b1;
    exp_y  = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_sat8 = 1'b0;
    m_sat2 = 1'b0;
  endtask

  // One serial bit enters the stream: match if the last PAT bits since the restart point equal the pattern.
  task automatic model_consume(input bit b, input bit clr);
    logic [3:0] win;
    bit hit;
    hist.push_back(b);
    if (hist.size() > PAT) void'(hist.pop_front());
    hit = 1'b0;
    if (hist.size() == PAT) begin
      win = 4'd0;
      foreach (hist[k]) win = {win[2:0], hist[k]};
      hit = (win == m_pat);
    end
    if (hit && !m_ovl) hist.delete();
    exp_y = hit;
    if (clr) begin
      m_cnt8 = 0; m_sat8 = 1'b0;
      m_cnt2 = 0; m_sat2 = 1'b0;
    end else if (hit) begin
      if (m_cnt8 < 255) begin m_cnt8++; if (m_cnt8 == 255) m_sat8 = 1'b1; end
      if (m_cnt2 < 3)   begin m_cnt2++; if (m_cnt2 == 3)   m_sat2 = 1'b1; end
    end
  endtask

  // Drives one word from IDLE through DONE back to IDLE, checking every cycle against the model.
  task automatic send_word(input logic [7:0] data, input int clr_at, input bit junk);
    logic [13:0] st_exp;
    checks++;
    if ({in_ready, in_ready2} !== 2'b11) begin
      errors++;
      $display("FAIL accept_ready word %h: got %b expected 11", data, {in_ready, in_ready2});
    end
    in_valid = 1'b1;
    in_data  = data;
    if (junk) begin
      cfg_we = 1'b1; cfg_pattern = 4'($urandom); cfg_overlap = 1'($urandom);
    end
    tick();
    exp_y = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({in_ready, ser_valid, busy, word_done, ser_bit, in_ready2, ser_valid2, busy2, word_done2, ser_bit2}
          !== {4'b0110, data[7-i], 4'b0110, data[7-i]}) begin
        errors++;
        $display("FAIL shift_ctrl word %h bit %0d: got %b expected %b", data, i,
                 {in_ready, ser_valid, busy, word_done, ser_bit}, {4'b0110, data[7-i]});
      end
      st_exp = {exp_y, exp_y, m_sat8, m_sat2, 8'(m_cnt8), 2'(m_cnt2)};
      checks++;
      if ({y, y2, sat, sat2, match_count, cnt2} !== st_exp) begin
        errors++;
        $display("FAIL shift_stat word %h bit %0d: got %b expected %b", data, i,
                 {y, y2, sat, sat2, match_count, cnt2}, st_exp);
      end
      if (junk) begin
        in_valid = 1'($urandom); in_data = 8'($urandom);
        cfg_we = 1'b1; cfg_pattern = 4'($urandom); cfg_overlap = 1'($urandom);
      end else begin
        in_valid = 1'b0; cfg_we = 1'b0;
      end
      cnt_clr = (i == clr_at);
      model_consume(data[7-i], i == clr_at);
      tick();
      cnt_clr = 1'b0;
    end
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    st_exp = {exp_y, exp_y, m_sat8, m_sat2, 8'(m_cnt8), 2'(m_cnt2)};
    checks++;
    if ({in_ready, ser_valid, busy, word_done, in_ready2, ser_valid2, busy2, word_done2, y, y2, sat, sat2, match_count, cnt2}
        !== {8'b0011_0011, st_exp}) begin
      errors++;
      $display("FAIL done_cycle word %h: got %b expected %b", data,
               {in_ready, ser_valid, busy, word_done, y, y2, sat, sat2, match_count, cnt2}, {4'b0011, st_exp});
    end
    tick();
    exp_y = 1'b0;
    st_exp = {exp_y, exp_y, m_sat8, m_sat2, 8'(m_cnt8), 2'(m_cnt2)};
    checks++;
    if ({in_ready, ser_valid, busy, word_done, in_ready2, ser_valid2, busy2, word_done2, y, y2, sat, sat2, match_count, cnt2}
        !== {8'b1000_1000, st_exp}) begin
      errors++;
      $display("FAIL idle_after word %h: got %b expected %b", data,
               {in_ready, ser_valid, busy, word_done, y, y2, sat, sat2, match_count, cnt2}, {4'b1000, st_exp});
    end
  endtask

  task automatic cfg_write(input logic [3:0] pat, input bit ovl);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_overlap = ovl;
    tick();
    cfg_we = 1'b0;
    m_pat = pat; m_ovl = ovl; hist.delete(); exp_y = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 1'b0; m_sat2 = 1'b0; exp_y = 1'b0;
    checks++;
    if ({match_count, cnt2, sat, sat2, y} !== 13'd0) begin
      errors++;
      $display("FAIL clear_counts: got %b expected 0", {match_count, cnt2, sat, sat2, y});
    end
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if ({in_ready, ser_valid, ser_bit, y, word_done, busy, sat, sat2, match_count, cnt2} !== 18'b1000_0000_0000_0000_00) begin
      errors++;
      $display("FAIL reset_state: got %b expected 100000000000000000",
               {in_ready, ser_valid, ser_bit, y, word_done, busy, sat, sat2, match_count, cnt2});
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_default();
    send_word(8'b0001_0001, -1, 1'b0);
    checks++;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL default_pattern_count: got %0d expected 2", match_count);
    end
  endtask

  task automatic test_overlap();
    cfg_write(4'b0101, 1'b1);
    clear_counts();
    send_word(8'b0101_0101, -1, 1'b0);
    checks++;
    if (match_count !== 8'd3) begin
      errors++;
      $display("FAIL overlap_count: got %0d expected 3", match_count);
    end
    clear_counts();
    cfg_write(4'b0101, 1'b0);
    send_word(8'b0101_0101, -1, 1'b0);
    checks++;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL nonoverlap_count: got %0d expected 2", match_count);
    end
  endtask

  task automatic test_cross_word();
    cfg_write(4'b0001, 1'b1);
    clear_counts();
    send_word(8'b1111_1000, -1, 1'b0);
    send_word(8'b1000_0000, -1, 1'b0);
    checks++;
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL cross_word_count: got %0d expected 1", match_count);
    end
  endtask

  task automatic test_saturation();
    cfg_write(4'b0001, 1'b1);
    clear_counts();
    for (int w = 0; w < 4; w++) send_word(8'b0000_0001, -1, 1'b0);
    checks++;
    if ({cnt2, sat2, match_count, sat} !== {2'd3, 1'b1, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL saturation: got cnt2=%0d sat2=%b cnt8=%0d sat8=%b expected 3 1 4 0", cnt2, sat2, match_count, sat);
    end
    // Clear lands on the cycle of the matching last bit: count drops to 0, y still pulses.
    send_word(8'b0000_0001, 7, 1'b0);
    checks++;
    if ({cnt2, sat2, match_count, sat} !== 12'd0) begin
      errors++;
      $display("FAIL clear_vs_match: got cnt2=%0d sat2=%b cnt8=%0d sat8=%b expected 0", cnt2, sat2, match_count, sat);
    end
  endtask

  task automatic test_cfg_ignored();
    cfg_write(4'b0001, 1'b1);
    clear_counts();
    send_word(8'b0001_0001, -1, 1'b1);
    send_word(8'b0001_0001, -1, 1'b0);
    checks++;
    if (match_count !== 8'd4) begin
      errors++;
      $display("FAIL cfg_ignored_count: got %0d expected 4", match_count);
    end
  endtask

  task automatic test_reset_mid();
    cfg_write(4'b0101, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'b0001_0001;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({in_ready, ser_valid, busy, word_done, y, in_ready2, busy2, match_count, cnt2, sat} !== {7'b1000010, 11'd0}) begin
      errors++;
      $display("FAIL reset_mid_async: got %b expected 100001000000000000",
               {in_ready, ser_valid, busy, word_done, y, in_ready2, busy2, match_count, cnt2, sat});
    end
    tick();
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({word_done, busy, in_ready, word_done2} !== 4'b0010) begin
        errors++;
        $display("FAIL reset_mid_no_done cycle %0d: got %b expected 0010", c, {word_done, busy, in_ready, word_done2});
      end
      tick();
    end
    // Pattern must be back to 0001 with overlap: this word matches twice.
    send_word(8'b0001_0001, -1, 1'b0);
    checks++;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL reset_mid_pattern: got %0d expected 2", match_count);
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 11);
      if (r == 0) begin
        cfg_write(4'($urandom), 1'($urandom));
      end else if (r == 1) begin
        clear_counts();
      end else begin
        send_word(8'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : -1,
                  1'($urandom_range(0, 3) == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_overlap();
    test_cross_word();
    test_saturation();
    test_cfg_ignored();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
